// File: rtl/voice_pkg.sv
// Shared types for the voice-capture front end: command codes and session states.
package voice_pkg;

  typedef enum logic [2:0] {
    WELCOME   = 3'd0,
    RECORDING = 3'd1,
    UP        = 3'd2,
    DOWN      = 3'd3,
    LEFT      = 3'd4,
    RIGHT     = 3'd5,
    STOP      = 3'd6,
    SILENCE   = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    RECORD,
    WAIT_RES,
    SHOW,
    ERROR
  } ctrl_state_e;

  // Only UP..SILENCE are legal classification results.
  function automatic logic is_result_cmd(input logic [2:0] code);
    return code >= 3'd2;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for the raw active-low key, plus falling-edge (press) detect.
module key_sync_edge (
  input  logic clk,
  input  logic rstb,
  input  logic key_n,
  output logic press,
  output logic pressed_lvl
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= key_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign press       = r_s3 & ~r_s2;
  assign pressed_lvl = ~r_s2;

endmodule

// File: rtl/rec_session_ctrl.sv
// One voice-capture session: debounce KEY0, open the recording window, wait for the
// ARM result (with timeout), then hold the command or error before re-arming.
module rec_session_ctrl
  import voice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REC_CYC      = 50_000_000,
  parameter int unsigned TIMEOUT_CYC  = 100_000_000,
  parameter int unsigned HOLD_CYC     = 100_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       key_n,
  input  logic       arm_ready,
  input  logic       res_valid,
  input  logic [2:0] res_cmd,
  output logic       rec_req,
  output logic [2:0] cmd,
  output logic       busy,
  output logic       err,
  output logic       res_pulse,
  output logic [7:0] sess_cnt
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(REC_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  ctrl_state_e      r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_press, w_pressed_lvl, w_enter_show;
  logic             r_rec_req, r_busy, r_err, r_res_pulse;
  logic [2:0]       r_cmd;
  logic [7:0]       r_sess;

  key_sync_edge u_key (
    .clk         (clk),
    .rstb        (rstb),
    .key_n       (key_n),
    .press       (w_press),
    .pressed_lvl (w_pressed_lvl)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_press && arm_ready) w_next = DEBOUNCE;
      DEBOUNCE: begin
        if (!w_pressed_lvl)        w_next = IDLE;
        else if (r_cnt == DEB_LAST) w_next = RECORD;
      end
      RECORD:   if (r_cnt == REC_LAST) w_next = WAIT_RES;
      // A result arriving on the timeout cycle takes priority over the timeout.
      WAIT_RES: begin
        if (res_valid)             w_next = is_result_cmd(res_cmd) ? SHOW : ERROR;
        else if (r_cnt == TO_LAST) w_next = ERROR;
      end
      SHOW, ERROR: if (r_cnt == HOLD_LAST) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  assign w_enter_show = (w_next == SHOW) && (r_state != SHOW);

  // Outputs are decoded from the next state so they are registered yet line up with r_state.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rec_req   <= 1'b0;
      r_cmd       <= WELCOME;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_res_pulse <= 1'b0;
      r_sess      <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
      r_rec_req   <= (w_next == RECORD);
      r_busy      <= (w_next != IDLE);
      r_err       <= (w_next == ERROR);
      r_res_pulse <= w_enter_show;
      if (w_enter_show) begin
        r_cmd  <= res_cmd;
        r_sess <= r_sess + 8'd1;
      end else if (w_next != SHOW) begin
        r_cmd <= (w_next == RECORD || w_next == WAIT_RES) ? RECORDING : WELCOME;
      end
    end
  end

  assign rec_req   = r_rec_req;
  assign cmd       = r_cmd;
  assign busy      = r_busy;
  assign err       = r_err;
  assign res_pulse = r_res_pulse;
  assign sess_cnt  = r_sess;

endmodule

// File: tb/tb_rec_session_ctrl.sv
// Self-checking bench for rec_session_ctrl against a deadline-based session model.
module tb_rec_session_ctrl;

  localparam int unsigned DEB = 4, REC = 10, TO = 20, HOLD = 5;

  logic       clk = 1'b0;
  logic       rstb = 1'b0, key_n = 1'b1, arm_ready = 1'b0, res_valid = 1'b0;
  logic [2:0] res_cmd = 3'd0;
  logic       rec_req, busy, err, res_pulse;
  logic [2:0] cmd;
  logic [7:0] sess_cnt;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  rec_session_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .REC_CYC      (REC),
    .TIMEOUT_CYC  (TO),
    .HOLD_CYC     (HOLD),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .key_n     (key_n),
    .arm_ready (arm_ready),
    .res_valid (res_valid),
    .res_cmd   (res_cmd),
    .rec_req   (rec_req),
    .cmd       (cmd),
    .busy      (busy),
    .err       (err),
    .res_pulse (res_pulse),
    .sess_cnt  (sess_cnt)
  );

  // Reference: phases with absolute-edge deadlines; key seen through a 2-edge latency window.
  localparam int M_IDLE = 0, M_DEB = 1, M_REC = 2, M_WAIT = 3, M_SHOW = 4, M_ERR = 5;
  int         m_phase = M_IDLE;
  longint     m_edge = 0, m_due = 0;
  logic [2:0] m_res = 3'd0;
  logic       m_pulse = 1'b0, m_press, m_lvl;
  logic [7:0] m_sess = 8'd0;
  logic [2:0] m_key = 3'b111;

  initial forever begin
    @(posedge clk);
    m_edge++;
    m_pulse = 1'b0;
    if (!rstb) begin
      m_phase = M_IDLE;
      m_sess  = 8'd0;
      m_key   = 3'b111;
    end else begin
      m_press = m_key[2] && !m_key[1];
      m_lvl   = !m_key[1];
      case (m_phase)
        M_IDLE: if (m_press && arm_ready) begin m_phase = M_DEB; m_due = m_edge + DEB; end
        M_DEB: begin
          if (!m_lvl) m_phase = M_IDLE;
          else if (m_edge == m_due) begin m_phase = M_REC; m_due = m_edge + REC; end
        end
        M_REC: if (m_edge == m_due) begin m_phase = M_WAIT; m_due = m_edge + TO; end
        M_WAIT: begin
          if (res_valid && res_cmd >= 3'd2) begin
            m_phase = M_SHOW; m_res = res_cmd; m_sess++; m_pulse = 1'b1; m_due = m_edge + HOLD;
          end else if (res_valid || m_edge == m_due) begin
            m_phase = M_ERR; m_due = m_edge + HOLD;
          end
        end
        default: if (m_edge == m_due) m_phase = M_IDLE;
      endcase
      m_key = {m_key[1:0], key_n};
    end
  end

  logic [14:0] obs, expv;
  assign obs  = {rec_req, cmd, busy, err, res_pulse, sess_cnt};
  assign expv = {m_phase == M_REC,
                 (m_phase == M_REC || m_phase == M_WAIT) ? 3'd1 : ((m_phase == M_SHOW) ? m_res : 3'd0),
                 m_phase != M_IDLE, m_phase == M_ERR, m_pulse, m_sess};

  task automatic test_reset();
    rstb = 1'b0; key_n = 1'b1; arm_ready = 1'b0; res_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (obs !== 15'd0) $display("FAIL reset_values got=%h want=%h", obs, 15'd0); else n_pass++;
    n_chk++; if (obs !== expv) $display("FAIL reset_model got=%h want=%h", obs, expv); else n_pass++;
    rstb = 1'b1;
  endtask

  task automatic test_good_session();
    int rec_hi = 0, cmd3 = 0, pulses = 0, fall = -1;
    arm_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL good_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (rec_req) rec_hi++;
      if (cmd == 3'd3) cmd3++;
      if (res_pulse) pulses++;
      if (fall < 0 && rec_hi > 0 && !rec_req) fall = c;
      key_n     = (c >= 29);
      res_valid = (fall >= 0 && c == fall + 4);
      res_cmd   = 3'd3;
    end
    n_chk++; if (rec_hi != REC) $display("FAIL good_rec_len got=%0d want=%0d", rec_hi, REC); else n_pass++;
    n_chk++; if (cmd3 != HOLD) $display("FAIL good_show_len got=%0d want=%0d", cmd3, HOLD); else n_pass++;
    n_chk++; if (pulses != 1) $display("FAIL good_pulse got=%0d want=1", pulses); else n_pass++;
    n_chk++; if (sess_cnt !== 8'd1) $display("FAIL good_sess got=%0d want=1", sess_cnt); else n_pass++;
    n_chk++; if ({cmd, busy} !== 4'd0) $display("FAIL good_rearm got=%h want=0", {cmd, busy}); else n_pass++;
  endtask

  task automatic test_debounce_abort();
    int rec_hi = 0, busy_seen = 0, cmd_nz = 0;
    arm_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL abort_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (rec_req) rec_hi++;
      if (busy) busy_seen++;
      if (cmd != 3'd0) cmd_nz++;
      key_n = (c >= 2);
    end
    n_chk++; if (rec_hi != 0) $display("FAIL abort_rec got=%0d want=0", rec_hi); else n_pass++;
    n_chk++; if (busy_seen == 0) $display("FAIL abort_busy_seen got=0 want>0"); else n_pass++;
    n_chk++; if (busy !== 1'b0 || cmd_nz != 0) $display("FAIL abort_idle got=%b/%0d want=0/0", busy, cmd_nz); else n_pass++;
  endtask

  task automatic test_timeout();
    int fall = -1, first_err = -1, errs = 0, cmd_nz = 0, rec_hi = 0;
    logic [7:0] s0;
    s0 = m_sess;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL timeout_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (rec_req) rec_hi++;
      if (fall < 0 && rec_hi > 0 && !rec_req) fall = c;
      if (err) begin errs++; if (first_err < 0) first_err = c; if (cmd != 3'd0) cmd_nz++; end
      key_n = (c >= 10);
    end
    n_chk++; if (first_err - fall != TO) $display("FAIL timeout_delay got=%0d want=%0d", first_err - fall, TO); else n_pass++;
    n_chk++; if (errs != HOLD) $display("FAIL timeout_err_len got=%0d want=%0d", errs, HOLD); else n_pass++;
    n_chk++; if (cmd_nz != 0 || sess_cnt !== s0) $display("FAIL timeout_side got=%0d/%0d want=0/%0d", cmd_nz, sess_cnt, s0); else n_pass++;
  endtask

  task automatic test_illegal_and_record_ignore();
    int rec_hi = 0, errs = 0, pulses = 0;
    logic [7:0] s0;
    s0 = m_sess;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL illegal_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (rec_req) rec_hi++;
      if (err) errs++;
      if (res_pulse) pulses++;
      key_n     = (c >= 10);
      res_valid = (c == 10) || (c == 22);
      res_cmd   = (c == 10) ? 3'd4 : 3'd1;
    end
    n_chk++; if (rec_hi != REC) $display("FAIL record_ignore_len got=%0d want=%0d", rec_hi, REC); else n_pass++;
    n_chk++; if (pulses != 0 || sess_cnt !== s0) $display("FAIL illegal_no_show got=%0d/%0d want=0/%0d", pulses, sess_cnt, s0); else n_pass++;
    n_chk++; if (errs != HOLD) $display("FAIL illegal_err_len got=%0d want=%0d", errs, HOLD); else n_pass++;
  endtask

  task automatic test_tie_and_misc();
    int fall = -1, rec_hi = 0, cmd6 = 0, errs = 0, pulses = 0, busy_seen = 0, rises = 0, rise2 = -1;
    logic prev_rec = 1'b0;
    logic [7:0] s0;
    s0 = m_sess;
    arm_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL tie_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (rec_req) rec_hi++;
      if (fall < 0 && rec_hi > 0 && !rec_req) fall = c;
      if (cmd == 3'd6) cmd6++;
      if (err) errs++;
      if (res_pulse) pulses++;
      key_n     = (c >= 10);
      res_valid = (fall >= 0 && c == fall + int'(TO) - 1);
      res_cmd   = 3'd6;
    end
    n_chk++; if (cmd6 != HOLD || pulses != 1) $display("FAIL tie_show got=%0d/%0d want=%0d/1", cmd6, pulses, HOLD); else n_pass++;
    n_chk++; if (errs != 0) $display("FAIL tie_err got=%0d want=0", errs); else n_pass++;
    n_chk++; if (sess_cnt !== s0 + 8'd1) $display("FAIL tie_sess got=%0d want=%0d", sess_cnt, s0 + 8'd1); else n_pass++;

    arm_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL notready_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (busy) busy_seen++;
      key_n = (c >= 8);
    end
    n_chk++; if (busy_seen != 0) $display("FAIL notready_busy got=%0d want=0", busy_seen); else n_pass++;

    arm_ready = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL held_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (rec_req && !prev_rec) begin rises++; if (rises == 2) rise2 = c; end
      prev_rec  = rec_req;
      key_n     = !(c < 80 || (c >= 90 && c < 100));
      res_valid = (c == 19);
      res_cmd   = 3'd7;
    end
    n_chk++; if (rises != 2 || rise2 < 90) $display("FAIL held_key_rearm got=%0d@%0d want=2@>=90", rises, rise2); else n_pass++;
  endtask

  task automatic test_reset_mid_record();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 11) begin
        n_chk++; if ({rec_req, cmd, busy} !== 5'd0) $display("FAIL midreset got=%b want=00000", {rec_req, cmd, busy}); else n_pass++;
      end
      n_chk++; if (obs !== expv) $display("FAIL midreset_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      key_n = (c >= 10);
      rstb  = (c != 10);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    for (int c = 0; c < 256 * 32 + 8; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL wrap_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (res_pulse) pulses++;
      key_n     = !(c < 256 * 32 && (c % 32) < 8);
      res_valid = (c < 256 * 32 && (c % 32) == 20);
      res_cmd   = 3'(2 + $urandom % 6);
    end
    n_chk++; if (pulses != 256) $display("FAIL wrap_sessions got=%0d want=256", pulses); else n_pass++;
    n_chk++; if (sess_cnt !== 8'd0) $display("FAIL wrap_sess got=%0d want=0", sess_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_chk++; if (obs !== expv) $display("FAIL random_trace c=%0d got=%h want=%h", c, obs, expv); else n_pass++;
      if (hold == 0) begin
        key_n = ~key_n;
        hold  = key_n ? int'($urandom_range(40, 1)) : int'($urandom_range(12, 1));
      end
      hold--;
      arm_ready = ($urandom % 8) != 0;
      res_valid = ($urandom % 6) == 0;
      res_cmd   = 3'($urandom);
      rstb      = ($urandom % 500) != 0;
    end
    rstb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_good_session();
    test_debounce_abort();
    test_timeout();
    test_illegal_and_record_ignore();
    test_tie_and_misc();
    test_reset_mid_record();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
